lfsr8_checker: RTL and testbench

Receive-side companion to the team's 8-bit LFSR pattern generator: accepts the generator's 8-bit words, self-synchronises to the sequence, and then checks every following word against a locally predicted value. It reports lock status, per-word error pulses and saturating error counters. It sits at the far end of a link or datapath under test, fed by the same word stream the generator drives.

---
 rtl/lfsr8_pkg.sv | 17 +
 rtl/lfsr8_step.sv | 11 +
 rtl/lfsr8_checker.sv | 148 ++++++++++++++
 tb/tb_lfsr8_checker.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/lfsr8_pkg.sv
// Shared definitions for the 8-bit LFSR pattern generator and checker:
// seed, checker FSM encoding and the sequence step function.
package lfsr8_pkg;

  localparam logic [7:0] LFSR8_SEED = 8'h01;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_e;

  // One sequence step; 0x00 maps to itself and is never a legal word.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] q);
    return {q[6], q[5], q[4] ^ q[0], q[3] ^ q[0], q[2] ^ q[0], q[1], q[0], q[7]};
  endfunction

endpackage

// File: rtl/lfsr8_step.sv
// Combinational single step of the 8-bit LFSR sequence.
module lfsr8_step
  import lfsr8_pkg::*;
(
  input  logic [7:0] q_i,
  output logic [7:0] n_o
);

  assign n_o = lfsr8_next(q_i);

endmodule

// File: rtl/lfsr8_checker.sv
// Self-synchronising checker for the 8-bit LFSR word stream.
// Define LFSR8_CHK_BITERR_EN to add the bit_err_count output.
module lfsr8_checker
  import lfsr8_pkg::*;
#(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic             lock_lost
`ifdef LFSR8_CHK_BITERR_EN
  ,
  output logic [CNT_W-1:0] bit_err_count
`endif
);

  localparam logic [3:0]       LOCK_N  = 4'(LOCK_COUNT);
  localparam logic [3:0]       LOSS_N  = 4'(LOSS_COUNT);
  localparam logic [3:0]       ONE4    = 4'd1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  chk_state_e       state_q, state_d;
  logic [7:0]       pred_q, pred_d;
  logic             seeded_q, seeded_d;
  logic [3:0]       match_q, match_d;
  logic [3:0]       miss_q, miss_d;
  logic             err_q, err_d;
  logic             ll_q, ll_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       n_din, n_pred;

  lfsr8_step u_step_din  (.q_i(din),    .n_o(n_din));
  lfsr8_step u_step_pred (.q_i(pred_q), .n_o(n_pred));

  always_comb begin
    state_d  = state_q;
    pred_d   = pred_q;
    seeded_d = seeded_q;
    match_d  = match_q;
    miss_d   = miss_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    ll_d     = 1'b0;
    if (din_valid) begin
      case (state_q)
        SEARCH: begin
          if (din == 8'h00) begin
            seeded_d = 1'b0;
            match_d  = 4'd0;
          end else if (!seeded_q) begin
            pred_d   = n_din;
            seeded_d = 1'b1;
            match_d  = 4'd0;
          end else if (din == pred_q) begin
            match_d = match_q + ONE4;
            pred_d  = n_din;
            if (match_q + ONE4 == LOCK_N) begin
              state_d = LOCKED;
              miss_d  = 4'd0;
            end
          end else begin
            pred_d  = n_din;
            match_d = 4'd0;
          end
        end
        LOCKED: begin
          // Flywheel: prediction advances regardless of what arrived.
          pred_d = n_pred;
          if (din == pred_q) begin
            miss_d = 4'd0;
          end else begin
            err_d  = 1'b1;
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
            miss_d = miss_q + ONE4;
            if (miss_q + ONE4 == LOSS_N) begin
              state_d  = SEARCH;
              ll_d     = 1'b1;
              seeded_d = 1'b0;
              match_d  = 4'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SEARCH;
      pred_q   <= 8'h00;
      seeded_q <= 1'b0;
      match_q  <= 4'd0;
      miss_q   <= 4'd0;
      err_q    <= 1'b0;
      ll_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pred_q   <= pred_d;
      seeded_q <= seeded_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      err_q    <= err_d;
      ll_q     <= ll_d;
      cnt_q    <= cnt_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err       = err_q;
  assign lock_lost = ll_q;
  assign err_count = cnt_q;

`ifdef LFSR8_CHK_BITERR_EN
  logic [CNT_W-1:0] bec_q, bec_d;
  logic [3:0]       pop;
  logic [7:0]       diff;
  logic [CNT_W:0]   bsum;

  always_comb begin
    diff = din ^ pred_q;
    pop  = 4'd0;
    for (int i = 0; i < 8; i++) pop = pop + {3'd0, diff[i]};
    // One carry bit is enough since a word adds at most 8.
    bsum  = {1'b0, bec_q} + (CNT_W+1)'(pop);
    bec_d = bec_q;
    if (din_valid && state_q == LOCKED)
      bec_d = bsum[CNT_W] ? CNT_MAX : bsum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) bec_q <= '0;
    else       bec_q <= bec_d;
  end

  assign bit_err_count = bec_q;
`endif

endmodule

// File: tb/tb_lfsr8_checker.sv
// Directed scoreboard bench for lfsr8_checker (CNT_W=4 to reach saturation).
module tb_lfsr8_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       locked, err, lock_lost;
  logic [3:0] err_count;
`ifdef LFSR8_CHK_BITERR_EN
  logic [3:0] bit_err_count;
`endif

  lfsr8_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .din_valid (din_valid),
    .locked    (locked),
    .err       (err),
    .err_count (err_count),
    .lock_lost (lock_lost)
`ifdef LFSR8_CHK_BITERR_EN
    ,
    .bit_err_count (bit_err_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         lk;
    bit         er;
    bit         ll;
    logic [3:0] cnt;
    bit         cb;
    logic [3:0] bec;
  } exp_t;

  exp_t       sb[$];
  int         nvec = 0;
  int         nbad = 0;
  logic [7:0] cur;
  logic [3:0] ec;

  // Galois-style reference step: rotate left, then fold bit 0 into taps 3..5.
  function automatic logic [7:0] ref_step(input logic [7:0] q);
    logic [7:0] r;
    r = {q[6:0], q[7]};
    if (q[0]) r = r ^ 8'h38;
    return r;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? 4'hF : c + 4'd1;
  endfunction

  task automatic vec(input bit rst, input bit v, input logic [7:0] d,
                     input bit el, input bit ee, input bit ell, input logic [3:0] ecnt,
                     input bit cb = 1'b0, input logic [3:0] eb = 4'd0);
    exp_t e;
    reset = rst; din_valid = v; din = d;
    e.lk = el; e.er = ee; e.ll = ell; e.cnt = ecnt; e.cb = cb; e.bec = eb;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic good(input bit el);
    vec(1'b0, 1'b1, cur, el, 1'b0, 1'b0, ec);
    cur = ref_step(cur);
  endtask

  task automatic bad(input logic [7:0] d, input bit el, input bit ell);
    ec = sat_inc(ec);
    vec(1'b0, 1'b1, d, el, 1'b1, ell, ec);
    cur = ref_step(cur);
  endtask

  task automatic relock();
    for (int i = 0; i < 4; i++) good(1'b0);
    good(1'b1);
  endtask

  task automatic do_reset();
    ec = 4'd0;
    vec(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd0);
  endtask

  // Monitor: one expectation per driven edge, checked mid-cycle after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        @(negedge clk);
        nvec++;
        if (locked !== e.lk) begin
          nbad++; $display("FAIL vec%0d locked: got %b want %b", nvec, locked, e.lk);
        end
        if (err !== e.er) begin
          nbad++; $display("FAIL vec%0d err: got %b want %b", nvec, err, e.er);
        end
        if (lock_lost !== e.ll) begin
          nbad++; $display("FAIL vec%0d lock_lost: got %b want %b", nvec, lock_lost, e.ll);
        end
        if (err_count !== e.cnt) begin
          nbad++; $display("FAIL vec%0d err_count: got %0d want %0d", nvec, err_count, e.cnt);
        end
`ifdef LFSR8_CHK_BITERR_EN
        if (e.cb && bit_err_count !== e.bec) begin
          nbad++; $display("FAIL vec%0d bit_err_count: got %0d want %0d", nvec, bit_err_count, e.bec);
        end
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    // Acquire lock from the seed and confirm the first words of the stream.
    do_reset();
    cur = 8'h01;
    vec(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 4'd0);
    vec(1'b0, 1'b1, 8'h3A, 1'b0, 1'b0, 1'b0, 4'd0);
    vec(1'b0, 1'b1, 8'h74, 1'b0, 1'b0, 1'b0, 4'd0);
    cur = 8'hE8;
    good(1'b0);
    good(1'b1);
    good(1'b1);
    good(1'b1);

    // Single bit-0 flip while locked.
    ec = 4'd1;
    vec(1'b0, 1'b1, cur ^ 8'h01, 1'b1, 1'b1, 1'b0, ec, 1'b1, 4'd1);
    cur = ref_step(cur);
    good(1'b1);
    vec(1'b0, 1'b1, cur, 1'b1, 1'b0, 1'b0, ec, 1'b1, 4'd1);
    cur = ref_step(cur);

    // Three 0xFF words drop lock; then relock on the running stream.
    bad(8'hFF, 1'b1, 1'b0);
    bad(8'hFF, 1'b1, 1'b0);
    bad(8'hFF, 1'b0, 1'b1);
    relock();

    // Zero words never seed or lock.
    do_reset();
    for (int i = 0; i < 3; i++) vec(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    vec(1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 4'd0);
    vec(1'b0, 1'b1, 8'h3A, 1'b0, 1'b0, 1'b0, 4'd0);
    vec(1'b0, 1'b1, 8'h74, 1'b0, 1'b0, 1'b0, 4'd0);
    vec(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0);
    cur = 8'hE8;
    relock();

    // Interleaved invalid cycles carry garbage that must be ignored.
    for (int i = 0; i < 6; i++) begin
      good(1'b1);
      vec(1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, ec);
    end

    // Miss counter clears on a match, so 2+2 misses keep lock.
    bad(~cur, 1'b1, 1'b0);
    bad(~cur, 1'b1, 1'b0);
    good(1'b1);
    bad(~cur, 1'b1, 1'b0);
    bad(~cur, 1'b1, 1'b0);
    good(1'b1);

    // Saturate err_count across six lock/loss rounds, then one more miss.
    do_reset();
    for (int r = 0; r < 6; r++) begin
      relock();
      bad(~cur, 1'b1, 1'b0);
      bad(~cur, 1'b1, 1'b0);
      bad(~cur, 1'b0, 1'b1);
    end
    relock();
    bad(~cur, 1'b1, 1'b0);
    vec(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 4'hF);

    // Mid-stream reset discards the word on that edge and clears everything.
    do_reset();
    good(1'b0);
    good(1'b0);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      nbad++;
      $display("FAIL scoreboard drain: got %0d pending want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
